// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the multiply-accumulate datapath: FSM states and
// accumulator width sizing.
package product_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

    // Wide enough that K products of two N-bit operands can never overflow.
    function automatic int acc_width(input int n, input int k);
        return 2 * n + $clog2(k);
    endfunction

endpackage

// File: rtl/product_accumulator_beat_counter.sv
// Counts accepted beats within a group; wraps to zero after the K-th beat and
// flags the last beat of the group.
module beat_counter #(
    parameter int K     = 4,
    parameter int CNT_W = $clog2(K)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_term
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= w_term ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_term = w_term;

endmodule

// File: rtl/product_accumulator.sv
// Accumulate half of the MAC datapath: sums K consecutive unsigned products
// and offers each finished sum on a valid/ready output handshake.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int N     = 4,
    parameter int K     = 4,
    parameter int ACC_W = acc_width(N, K)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2*N-1:0]   i_prod,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_acc_out
);

    localparam int CNT_W = $clog2(K);

    acc_state_t       r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] w_cnt;
    logic             w_term;
    logic             w_accept;
    logic [ACC_W-1:0] w_prod_ext;

    assign o_in_ready = (r_state == ACCUM) && !i_clr;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_prod_ext = ACC_W'(i_prod);

    beat_counter #(.K(K), .CNT_W(CNT_W)) u_beat_counter (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (i_clr),
        .i_inc  (w_accept),
        .o_cnt  (w_cnt),
        .o_term (w_term)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_clr) begin
            w_state_nxt = ACCUM;
        end else begin
            case (r_state)
                ACCUM: if (w_accept && w_term) w_state_nxt = DONE;
                DONE:  if (i_out_ready)        w_state_nxt = ACCUM;
                default:                       w_state_nxt = ACCUM;
            endcase
        end
    end

    // First beat of a group loads rather than adds, so no separate clear of
    // the previous result is needed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= (w_cnt == '0) ? w_prod_ext : r_acc + w_prod_ext;
        end
    end

    assign o_out_valid = (r_state == DONE);
    assign o_acc_out   = r_acc;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed scoreboard bench for product_accumulator.
module tb_product_accumulator;

    localparam int N     = 4;
    localparam int K     = 4;
    localparam int ACC_W = 2 * N + $clog2(K);

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_clr = 1'b0;
    logic             i_in_valid = 1'b0;
    logic             o_in_ready;
    logic [2*N-1:0]   i_prod = '0;
    logic             o_out_valid;
    logic             i_out_ready = 1'b0;
    logic [ACC_W-1:0] o_acc_out;

    product_accumulator #(.N(N), .K(K)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (i_clr),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_prod      (i_prod),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_acc_out   (o_acc_out)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: products of the open group, whether a result is
    // waiting downstream, and the queue of sums the DUT must present.
    int grp[$];
    bit pend      = 1'b0;
    bit zero_flag = 1'b1;
    int exp_q[$];
    bit mon_en    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc(input bit v, input int p, input bit ordy, input bit c, input bit r);
        int s;
        @(negedge i_clk);
        i_in_valid  = v;
        i_prod      = p[2*N-1:0];
        i_out_ready = ordy;
        i_clr       = c;
        i_rst       = r;
        #1;
        chk("in_ready", int'(o_in_ready), int'(!pend && !c));
        chk("out_valid", int'(o_out_valid), int'(pend));
        if (zero_flag) chk("acc_after_reset", int'(o_acc_out), 0);
        @(posedge i_clk);
        if (r || c) begin
            if (pend) void'(exp_q.pop_back());
            pend = 1'b0;
            grp.delete();
            if (r) zero_flag = 1'b1;
        end else if (pend) begin
            if (ordy) pend = 1'b0;
        end else if (v) begin
            grp.push_back(p);
            zero_flag = 1'b0;
            if (grp.size() == K) begin
                s = 0;
                foreach (grp[i]) s += grp[i];
                exp_q.push_back(s);
                grp.delete();
                pend = 1'b1;
            end
        end
    endtask

    // Monitor: whenever a sum is presented it must match the oldest expected
    // one; it is retired only when the handshake actually completes.
    initial begin
        forever begin
            @(negedge i_clk);
            #2;
            if (mon_en && o_out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", int'(o_acc_out), -1);
                end else begin
                    chk("acc_out", int'(o_acc_out), exp_q[0]);
                    if (i_out_ready && !i_rst && !i_clr) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge i_clk);
        mon_en = 1'b1;

        // Saturated products back to back; idle cycle shows in_ready returns.
        repeat (4) cyc(1, 225, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        // Gapped beats, then a held result under back-pressure.
        for (int i = 1; i <= 4; i++) begin
            cyc(1, i, 0, 0, 0);
            if (i < 4) repeat (2) cyc(0, 0, 0, 0, 0);
        end
        repeat (5) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        // clr discards a partial group and blocks the coincident beat.
        cyc(1, 5, 1, 0, 0);
        cyc(1, 7, 1, 0, 0);
        cyc(1, 9, 1, 1, 0);
        repeat (4) cyc(1, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        // clr in DONE drops the result even with out_ready high.
        repeat (4) cyc(1, 3, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);

        // Reset while a result is pending.
        repeat (4) cyc(1, 6, 0, 0, 0);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 0);

        // Zero group followed by a group whose first beat must overwrite.
        repeat (4) cyc(1, 0, 1, 0, 0);
        cyc(1, 15, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(99) < 70,
                int'($urandom_range(15) * $urandom_range(15)),
                $urandom_range(99) < 60,
                $urandom_range(99) < 3,
                $urandom_range(199) < 2);
        end

        repeat (4) cyc(0, 0, 1, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
